// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared state encoding and constants for the instruction fetch unit
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } fetch_state_e;

  localparam logic [31:0] MIPS_NOP   = 32'h0000_0000;
  localparam logic [1:0]  ALIGN_MASK = 2'b11;

  function automatic logic is_word_aligned(input logic [31:0] addr);
    return (addr[1:0] & ALIGN_MASK) == 2'b00;
  endfunction

endpackage

// File: rtl/fetch_timeout_cnt.sv
// rtl/fetch_timeout_cnt.sv - REQ wait-cycle counter, flags the terminal unanswered cycle
module fetch_timeout_cnt #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear)       cnt_d = '0;
    else if (enable) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  // Expires on the edge that would bring the count up to TIMEOUT_CYCLES.
  assign expired = enable && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/inst_fetch_unit.sv
// rtl/inst_fetch_unit.sv - multi-cycle MIPS fetch FSM driving instruction memory and IR load
// Optional REQ timeout abort enabled by defining FETCH_TIMEOUT_EN.
module inst_fetch_unit
  import fetch_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES = 16,
  parameter logic [31:0] RESET_INST     = MIPS_NOP
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        fetch_req,
  input  logic        flush,
  input  logic [31:0] PC,
  output logic [31:0] mem_addr,
  output logic        mem_rd,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic [31:0] instruction,
  output logic        IRWr,
  output logic        fetch_busy,
  output logic        fetch_err
);

  fetch_state_e state_q, state_d;
  logic [31:0]  mem_addr_q, mem_addr_d;
  logic [31:0]  instr_q, instr_d;
  logic         err_q, err_d;
  logic         to_expired;

`ifdef FETCH_TIMEOUT_EN
  fetch_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (CLK),
    .rst_n  (RST_N),
    .clear  (state_q != REQ),
    .enable ((state_q == REQ) && !mem_ready),
    .expired(to_expired)
  );
`else
  assign to_expired = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Flush outranks everything; a coincident mem_ready is dropped.
  always_comb begin
    state_d    = state_q;
    mem_addr_d = mem_addr_q;
    instr_d    = instr_q;
    err_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (!flush && fetch_req) begin
          if (is_word_aligned(PC)) begin
            state_d    = REQ;
            mem_addr_d = PC;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      REQ: begin
        if (flush) begin
          state_d = IDLE;
        end else if (mem_ready) begin
          instr_d = mem_rdata;
          state_d = DONE;
        end else if (to_expired) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_rd     = (state_q == REQ);
    IRWr       = (state_q == DONE) && !flush;
    fetch_busy = (state_q == REQ) || (state_q == DONE);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      mem_addr_q <= '0;
      instr_q    <= RESET_INST;
      err_q      <= 1'b0;
    end else begin
      mem_addr_q <= mem_addr_d;
      instr_q    <= instr_d;
      err_q      <= err_d;
    end
  end

  assign mem_addr    = mem_addr_q;
  assign instruction = instr_q;
  assign fetch_err   = err_q;

endmodule
